conv3x3_stream: RTL and testbench
=================================

Name: conv3x3_stream

Overview:
Parametrised 3x3 streaming convolution engine for the camera pixel path, successor to the fixed 640-wide Sobel stage.
- Takes one pixel per valid cycle and tolerates bubbles.
- Tracks frame position with column/row counters; holds two rows in line buffers.
- Produces Sobel magnitude, thresholded Sobel, Gaussian blur or window-centre output with fixed latency.
- Sits between Bayer-to-gray conversion and the display/frame-buffer writer.

Parameters:
PIX_W, 12, pixel width in bits
IMG_W, 640, pixels per line (line buffer depth)
IMG_H, 480, lines per frame

Ports:
iCLK  input  1  clock
iRST  input  1  asynchronous reset, active-high
iPIX  input  PIX_W  input pixel
iDVAL  input  1  input pixel valid; 0 = bubble
iSOF  input  1  start of frame, qualified by iDVAL; marks pixel (0,0)
iCONV_EN  input  1  1 = convolve, 0 = delayed bypass
iMODE  input  2  0 Sobel mag, 1 Sobel threshold, 2 Gaussian, 3 centre
iTHRESH  input  PIX_W  threshold for mode 1
oPIX  output  PIX_W  output pixel
oDVAL  output  1  output valid

Behaviour:
- Reset (async, iRST=1): oPIX=0, oDVAL=0. Counters x=y=0. Window regs and pipeline valids cleared. Line buffer contents are don't-care.
- Counters advance only when iDVAL=1:
  - x wraps at IMG_W-1 and increments y.
  - y wraps at IMG_H-1 to 0.
  - iSOF&iDVAL forces the current pixel to (0,0), overriding the counters.
- Window: on each valid pixel at (x,y), the 3x3 window covers cols x-2..x and rows y-2..y; centre is (x-1,y-1). Line buffers are read and written at address x in the same cycle (read-before-write).
- Window complete iff x>=2 and y>=2. An incomplete window outputs 0 in modes 0-3; one output is still emitted per input.
- Latency: exactly 3 iCLK cycles.
  - Stage 1: window shift.
  - Stage 2: kernel sums.
  - Stage 3: abs/saturate/select, registered to oPIX.
  - Every iDVAL=1 yields oDVAL=1 exactly 3 cycles later. Bubbles propagate as oDVAL=0 and oPIX holds its last value.
- Arithmetic:
  - Gx, Gy are signed PIX_W+3 bits, using the standard Sobel kernels.
  - Mode 0: |Gx|+|Gy| (PIX_W+3 unsigned), saturated to 2^PIX_W-1.
  - Mode 1: output 2^PIX_W-1 if the mode-0 unsaturated magnitude >= iTHRESH, else 0.
  - Mode 2: [1 2 1;2 4 2;1 2 1] sum (PIX_W+4 bits), >>4, truncate.
  - Mode 3: centre pixel.
- Config latching: iMODE, iTHRESH and iCONV_EN are sampled into shadow registers on the first valid pixel of a frame (iSOF, or counter wrap to (0,0)). Mid-frame changes take effect at the next frame.
- Bypass (shadow iCONV_EN=0): oPIX = the iPIX accepted 3 cycles earlier. Counters and line buffers still run.
- Simultaneous iSOF and counter wrap: iSOF wins; same (0,0) result.
- Reset mid-frame: immediate clear. The next frame must restart with iSOF or from x=y=0.

Optional Feature:
CONV_EDGE_STATS_EN
- Defined: adds output oEDGE_CNT[$clog2(IMG_W*IMG_H+1)-1:0] and oEDGE_VLD.
  - Counts oDVAL outputs with oPIX!=0 during a frame.
  - Latches the count into oEDGE_CNT and pulses oEDGE_VLD for one cycle, 3 cycles after the last pixel (IMG_W-1,IMG_H-1) is accepted.
  - Count restarts at 0; both outputs reset to 0.
- Undefined: ports and logic absent.

Decomposition:
- Package conv3x3_pkg:
  - mode enum: MODE_SOBEL, MODE_THRESH, MODE_GAUSS, MODE_CENTRE.
  - pipeline latency constant LAT=3.
  - kernel coefficient constants.
  - width helper functions (grad width = PIX_W+3, blur width = PIX_W+4).
- Sub-module conv_line_buf: behavioural single-clock RAM, depth IMG_W, width PIX_W, synchronous read-before-write. Instantiated twice.

Test Plan (IMG_W=8, IMG_H=6, PIX_W=12):
- Vertical edge: cols 0-3=0, cols 4-7=4095 every row, mode 0 -> rows y>=2 output [0,0,0,0,4095,4095,0,0]; rows 0-1 all 0; oDVAL 3 cycles after each iDVAL.
- Threshold: pixel=100*x, mode 1 -> complete windows give |Gx|=800. iTHRESH=800 gives 4095; iTHRESH=801 gives 0.
- Gaussian: constant 1000 frame, mode 2 -> 1000 for complete windows, 0 elsewhere.
- Bubbles and bypass:
  - Repeat the vertical-edge frame with iDVAL=0 on alternate cycles -> identical valid-output sequence.
  - iCONV_EN=0 -> oPIX equals iPIX delayed 3 cycles.
- Config latching and reset: iMODE 0->2 at pixel (3,3) -> frame stays mode 0, next frame mode 2. iRST pulse mid-row -> oDVAL=0 and oPIX=0 immediately; the next iSOF frame is correct.
- CONV_EDGE_STATS_EN: vertical-edge frame -> oEDGE_CNT=8 (4 rows x 2), oEDGE_VLD one-cycle pulse.

Source files
------------

// File: rtl/conv3x3_pkg.sv
// Shared types and constants for the 3x3 streaming convolution engine.
package conv3x3_pkg;

  typedef enum logic [1:0] {
    MODE_SOBEL  = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_GAUSS  = 2'd2,
    MODE_CENTRE = 2'd3
  } mode_e;

  localparam int LAT = 3;

  // Sobel rows/cols are weighted 1-2-1; Gaussian is the 1-2-1 outer product
  localparam int K_SOBEL_MID    = 2;
  localparam int K_GAUSS_CORNER = 1;
  localparam int K_GAUSS_EDGE   = 2;
  localparam int K_GAUSS_CTR    = 4;
  localparam int GAUSS_SHIFT    = 4;

  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int blur_w(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel stream bus for conv3x3_stream: input pixel/valid/SOF and output pixel/valid.
interface conv3x3_stream_if #(parameter int PIX_W = 12);
  logic [PIX_W-1:0] iPIX;
  logic             iDVAL;
  logic             iSOF;
  logic [PIX_W-1:0] oPIX;
  logic             oDVAL;

  modport master (output iPIX, iDVAL, iSOF, input oPIX, oDVAL);
  modport slave  (input iPIX, iDVAL, iSOF, output oPIX, oDVAL);
endinterface

// File: rtl/conv_line_buf.sv
// One-line pixel store: single clock, synchronous read-before-write at one address.
module conv_line_buf #(
  parameter int DEPTH = 640,
  parameter int W     = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          iCLK,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge iCLK) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end
endmodule

// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution (Sobel / threshold / Gaussian / centre / bypass), 3-cycle latency.
// Optional CONV_EDGE_STATS_EN adds a per-frame count of non-zero outputs.
module conv3x3_stream
  import conv3x3_pkg::*;
#(
  parameter int PIX_W = 12,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             iCLK,
  input  logic             iRST,
  conv3x3_stream_if.slave  bus,
  input  logic             iCONV_EN,
  input  logic [1:0]       iMODE,
  input  logic [PIX_W-1:0] iTHRESH
`ifdef CONV_EDGE_STATS_EN
  ,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] oEDGE_CNT,
  output logic             oEDGE_VLD
`endif
);
  localparam int GW = grad_w(PIX_W);
  localparam int BW = blur_w(PIX_W);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [PIX_W-1:0] MAXP = '1;

  typedef logic [2:0][PIX_W-1:0] col_t;  // [0]=row y-2, [1]=row y-1, [2]=row y

  function automatic logic [GW-1:0] sob3(input logic [PIX_W-1:0] a, m, b);
    return GW'(a) + GW'(K_SOBEL_MID) * GW'(m) + GW'(b);
  endfunction

  // ---- stage 0: frame position and config ----
  logic [XW-1:0] x_cnt, px;
  logic [YW-1:0] y_cnt, py;
  logic          eol, eof, first, bank;
  logic          sh_en, cur_en;
  mode_e         sh_mode, cur_mode;
  logic [PIX_W-1:0] sh_th, cur_th;
  logic [LAT:0]  vld_pipe;

  assign vld_pipe[0] = bus.iDVAL;
  assign px    = bus.iSOF ? '0 : x_cnt;
  assign py    = bus.iSOF ? '0 : y_cnt;
  assign eol   = (px == XW'(IMG_W-1));
  assign eof   = eol && (py == YW'(IMG_H-1));
  assign first = (px == '0) && (py == '0);
  // the frame's first pixel already uses the freshly sampled config
  assign cur_en   = first ? iCONV_EN        : sh_en;
  assign cur_mode = first ? mode_e'(iMODE)  : sh_mode;
  assign cur_th   = first ? iTHRESH         : sh_th;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      bank    <= 1'b0;
      sh_en   <= 1'b0;
      sh_mode <= MODE_SOBEL;
      sh_th   <= '0;
    end else if (bus.iDVAL) begin
      x_cnt <= eol ? '0 : px + XW'(1);
      y_cnt <= eol ? (eof ? '0 : py + YW'(1)) : py;
      bank  <= bank ^ eol;
      if (first) begin
        sh_en   <= iCONV_EN;
        sh_mode <= mode_e'(iMODE);
        sh_th   <= iTHRESH;
      end
    end
  end

  // Ping-pong line buffers: the bank written this row holds row y-2, the other row y-1.
  logic [PIX_W-1:0] rd0, rd1;

  conv_line_buf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb0 (
    .iCLK(iCLK), .en(bus.iDVAL), .we(~bank), .addr(px), .wdata(bus.iPIX), .rdata(rd0));
  conv_line_buf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
    .iCLK(iCLK), .en(bus.iDVAL), .we(bank), .addr(px), .wdata(bus.iPIX), .rdata(rd1));

  // ---- stage 1: window shift ----
  logic [PIX_W-1:0] s1_pix, s1_th;
  logic             s1_bank, s1_cpl, s1_en, s1_last;
  mode_e            s1_mode;
  col_t             col0, col1, col2;

  assign col0 = {s1_pix, (s1_bank ? rd0 : rd1), (s1_bank ? rd1 : rd0)};

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      vld_pipe[LAT:1] <= '0;
      s1_pix  <= '0;
      s1_bank <= 1'b0;
      s1_cpl  <= 1'b0;
      s1_en   <= 1'b0;
      s1_mode <= MODE_SOBEL;
      s1_th   <= '0;
      s1_last <= 1'b0;
      col1    <= '0;
      col2    <= '0;
    end else begin
      vld_pipe[LAT:1] <= vld_pipe[LAT-1:0];
      if (bus.iDVAL) begin
        col2    <= col1;
        col1    <= col0;
        s1_pix  <= bus.iPIX;
        s1_bank <= bank;
        s1_cpl  <= (px > XW'(1)) && (py > YW'(1));
        s1_en   <= cur_en;
        s1_mode <= cur_mode;
        s1_th   <= cur_th;
        s1_last <= eof;
      end
    end
  end

  // ---- stage 2: kernel sums ----
  logic signed [GW-1:0] gx, gy, s2_gx, s2_gy;
  logic [BW-1:0]        blur, s2_blur;
  logic [PIX_W-1:0]     s2_ctr, s2_byp, s2_th;
  logic                 s2_cpl, s2_en, s2_last;
  mode_e                s2_mode;

  assign gx = $signed(sob3(col0[0], col0[1], col0[2])) - $signed(sob3(col2[0], col2[1], col2[2]));
  assign gy = $signed(sob3(col2[2], col1[2], col0[2])) - $signed(sob3(col2[0], col1[0], col0[0]));
  assign blur = BW'(K_GAUSS_CORNER) * (BW'(col2[0]) + BW'(col2[2]) + BW'(col0[0]) + BW'(col0[2]))
              + BW'(K_GAUSS_EDGE)   * (BW'(col2[1]) + BW'(col0[1]) + BW'(col1[0]) + BW'(col1[2]))
              + BW'(K_GAUSS_CTR)    * BW'(col1[1]);

  always_ff @(posedge iCLK) begin
    if (vld_pipe[1]) begin
      s2_gx   <= gx;
      s2_gy   <= gy;
      s2_blur <= blur;
      s2_ctr  <= col1[1];
      s2_byp  <= s1_pix;
      s2_cpl  <= s1_cpl;
      s2_en   <= s1_en;
      s2_mode <= s1_mode;
      s2_th   <= s1_th;
      s2_last <= s1_last;
    end
  end

  // ---- stage 3: abs / saturate / select ----
  logic [GW-1:0]    ax, ay, mag;
  logic [PIX_W-1:0] res, o_pix;

  assign ax  = s2_gx[GW-1] ? $unsigned(-s2_gx) : $unsigned(s2_gx);
  assign ay  = s2_gy[GW-1] ? $unsigned(-s2_gy) : $unsigned(s2_gy);
  assign mag = ax + ay;

  always_comb begin
    res = '0;
    if (!s2_en) res = s2_byp;
    else if (s2_cpl) begin
      case (s2_mode)
        MODE_SOBEL:  res = (mag > GW'(MAXP)) ? MAXP : mag[PIX_W-1:0];
        MODE_THRESH: res = (mag >= GW'(s2_th)) ? MAXP : '0;
        MODE_GAUSS:  res = s2_blur[GAUSS_SHIFT +: PIX_W];
        default:     res = s2_ctr;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)             o_pix <= '0;
    else if (vld_pipe[2]) o_pix <= res;
  end

  assign bus.oPIX  = o_pix;
  assign bus.oDVAL = vld_pipe[LAT];

`ifdef CONV_EDGE_STATS_EN
  localparam int CW = $clog2(IMG_W*IMG_H+1);
  logic [CW-1:0] edge_cnt;

  // published alongside the last pixel's output, then restarts
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      edge_cnt  <= '0;
      oEDGE_CNT <= '0;
      oEDGE_VLD <= 1'b0;
    end else begin
      oEDGE_VLD <= 1'b0;
      if (vld_pipe[2]) begin
        if (s2_last) begin
          oEDGE_CNT <= edge_cnt + CW'(res != '0);
          oEDGE_VLD <= 1'b1;
          edge_cnt  <= '0;
        end else begin
          edge_cnt  <= edge_cnt + CW'(res != '0);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed self-checking bench for conv3x3_stream on an 8x6 frame.
module tb_conv3x3_stream;
  localparam int PW = 12, W = 8, H = 6, N = W * H;

  logic iCLK = 1'b0;
  logic iRST;
  logic conv_en;
  logic [1:0] mode;
  logic [PW-1:0] thresh;
  int checks = 0, errors = 0, cyc = 0;

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  conv3x3_stream_if #(.PIX_W(PW)) bus ();

`ifdef CONV_EDGE_STATS_EN
  logic [5:0] edge_cnt;
  logic       edge_vld;
`endif

  conv3x3_stream #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .iCLK(iCLK), .iRST(iRST), .bus(bus),
    .iCONV_EN(conv_en), .iMODE(mode), .iTHRESH(thresh)
`ifdef CONV_EDGE_STATS_EN
    , .oEDGE_CNT(edge_cnt), .oEDGE_VLD(edge_vld)
`endif
  );

  int frame [N];
  int expv [N];
  int in_cyc[$], out_q[$], out_cyc[$];
  int hold_err;
  logic [PW-1:0] last_out;
  int ve_row [W] = '{0, 0, 0, 0, 4095, 4095, 0, 0};
  int ge_row [W] = '{0, 0, 0, 0, 1023, 3071, 4095, 4095};
  int edge_pulses, edge_val, edge_cyc;

  always @(negedge iCLK) begin
    if (bus.oDVAL) begin
      out_q.push_back(int'(bus.oPIX));
      out_cyc.push_back(cyc);
      last_out = bus.oPIX;
    end else if (!iRST && bus.oPIX !== last_out) hold_err++;
`ifdef CONV_EDGE_STATS_EN
    if (edge_vld) begin
      edge_pulses++;
      edge_val = int'(edge_cnt);
      edge_cyc = cyc;
    end
`endif
  end

  task automatic clear_mon();
    in_cyc.delete(); out_q.delete(); out_cyc.delete();
    hold_err = 0; last_out = bus.oPIX; edge_pulses = 0;
  endtask

  task automatic fill_vert();
    for (int i = 0; i < N; i++) frame[i] = ((i % W) >= 4) ? 4095 : 0;
  endtask

  task automatic exp_rows(input int sel);  // 0: Sobel edge, 1: Gaussian of edge
    for (int i = 0; i < N; i++)
      expv[i] = (i / W < 2) ? 0 : (sel == 0 ? ve_row[i % W] : ge_row[i % W]);
  endtask

  task automatic drive_frame(input bit bub, input int chg_idx, input logic [1:0] chg_mode);
    for (int i = 0; i < N; i++) begin
      @(posedge iCLK); #1;
      if (i == chg_idx) mode = chg_mode;
      bus.iPIX = PW'(frame[i]); bus.iDVAL = 1'b1; bus.iSOF = (i == 0);
      in_cyc.push_back(cyc);
      if (bub) begin
        @(posedge iCLK); #1;
        bus.iDVAL = 1'b0; bus.iSOF = 1'b0; bus.iPIX = 12'hABC;
      end
    end
    @(posedge iCLK); #1;
    bus.iDVAL = 1'b0; bus.iSOF = 1'b0;
    repeat (6) @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;
    checks++; if (bus.oDVAL !== 1'b0) begin errors++; $display("FAIL reset_dval: got %b expected 0", bus.oDVAL); end
    checks++; if (bus.oPIX !== 12'd0) begin errors++; $display("FAIL reset_pix: got %0d expected 0", bus.oPIX); end
    iRST = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    checks++; if (bus.oDVAL !== 1'b0) begin errors++; $display("FAIL idle_dval: got %b expected 0", bus.oDVAL); end
  endtask

  task automatic test_vertical_edge();
    fill_vert(); exp_rows(0); conv_en = 1'b1; mode = 2'd0; clear_mon();
    drive_frame(1'b0, -1, 2'd0);
    checks++; if (out_q.size() != N) begin errors++; $display("FAIL edge_count: got %0d expected %0d", out_q.size(), N); end
    for (int i = 0; i < out_q.size() && i < N; i++) begin
      checks++; if (out_q[i] !== expv[i]) begin errors++; $display("FAIL edge_pix[%0d]: got %0d expected %0d", i, out_q[i], expv[i]); end
      checks++; if (out_cyc[i] - in_cyc[i] !== 3) begin errors++; $display("FAIL edge_lat[%0d]: got %0d expected 3", i, out_cyc[i] - in_cyc[i]); end
    end
  endtask

  task automatic test_threshold();
    for (int i = 0; i < N; i++) frame[i] = 100 * (i % W);
    conv_en = 1'b1; mode = 2'd1;
    for (int t = 0; t < 2; t++) begin
      thresh = (t == 0) ? 12'd800 : 12'd801;
      clear_mon();
      drive_frame(1'b0, -1, 2'd1);
      checks++; if (out_q.size() != N) begin errors++; $display("FAIL thr_count: got %0d expected %0d", out_q.size(), N); end
      for (int i = 0; i < out_q.size() && i < N; i++) begin
        int e;
        e = (t == 0 && (i % W) >= 2 && (i / W) >= 2) ? 4095 : 0;
        checks++; if (out_q[i] !== e) begin errors++; $display("FAIL thr%0d_pix[%0d]: got %0d expected %0d", t, i, out_q[i], e); end
      end
    end
  endtask

  task automatic test_gauss();
    for (int i = 0; i < N; i++) frame[i] = 1000;
    conv_en = 1'b1; mode = 2'd2; clear_mon();
    drive_frame(1'b0, -1, 2'd2);
    checks++; if (out_q.size() != N) begin errors++; $display("FAIL gauss_count: got %0d expected %0d", out_q.size(), N); end
    for (int i = 0; i < out_q.size() && i < N; i++) begin
      int e;
      e = ((i % W) >= 2 && (i / W) >= 2) ? 1000 : 0;
      checks++; if (out_q[i] !== e) begin errors++; $display("FAIL gauss_pix[%0d]: got %0d expected %0d", i, out_q[i], e); end
    end
  endtask

  task automatic test_bubbles();
    fill_vert(); exp_rows(0); conv_en = 1'b1; mode = 2'd0; clear_mon();
    drive_frame(1'b1, -1, 2'd0);
    checks++; if (out_q.size() != N) begin errors++; $display("FAIL bub_count: got %0d expected %0d", out_q.size(), N); end
    for (int i = 0; i < out_q.size() && i < N; i++) begin
      checks++; if (out_q[i] !== expv[i]) begin errors++; $display("FAIL bub_pix[%0d]: got %0d expected %0d", i, out_q[i], expv[i]); end
      checks++; if (out_cyc[i] - in_cyc[i] !== 3) begin errors++; $display("FAIL bub_lat[%0d]: got %0d expected 3", i, out_cyc[i] - in_cyc[i]); end
    end
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL bub_hold: got %0d changes expected 0", hold_err); end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < N; i++) frame[i] = (i * 37 + 5) % 4096;
    conv_en = 1'b0; mode = 2'd0; clear_mon();
    drive_frame(1'b0, -1, 2'd0);
    checks++; if (out_q.size() != N) begin errors++; $display("FAIL byp_count: got %0d expected %0d", out_q.size(), N); end
    for (int i = 0; i < out_q.size() && i < N; i++) begin
      checks++; if (out_q[i] !== frame[i]) begin errors++; $display("FAIL byp_pix[%0d]: got %0d expected %0d", i, out_q[i], frame[i]); end
    end
    conv_en = 1'b1;
  endtask

  task automatic test_config_latch();
    fill_vert(); conv_en = 1'b1; mode = 2'd0;
    for (int f = 0; f < 2; f++) begin
      clear_mon(); exp_rows(f);
      drive_frame(1'b0, (f == 0) ? 27 : -1, 2'd2);
      checks++; if (out_q.size() != N) begin errors++; $display("FAIL cfg%0d_count: got %0d expected %0d", f, out_q.size(), N); end
      for (int i = 0; i < out_q.size() && i < N; i++) begin
        checks++; if (out_q[i] !== expv[i]) begin errors++; $display("FAIL cfg%0d_pix[%0d]: got %0d expected %0d", f, i, out_q[i], expv[i]); end
      end
    end
  endtask

  task automatic test_mid_reset();
    fill_vert(); conv_en = 1'b1; mode = 2'd0; clear_mon();
    for (int i = 0; i < 25; i++) begin
      @(posedge iCLK); #1;
      bus.iPIX = PW'(frame[i]); bus.iDVAL = 1'b1; bus.iSOF = (i == 0);
    end
    #1;
    checks++; if (bus.oDVAL !== 1'b1 || bus.oPIX !== 12'd4095) begin
      errors++; $display("FAIL pre_reset: got dval=%b pix=%0d expected dval=1 pix=4095", bus.oDVAL, bus.oPIX);
    end
    #1; iRST = 1'b1; bus.iDVAL = 1'b0; bus.iSOF = 1'b0;
    #1;
    checks++; if (bus.oDVAL !== 1'b0 || bus.oPIX !== 12'd0) begin
      errors++; $display("FAIL mid_reset: got dval=%b pix=%0d expected dval=0 pix=0", bus.oDVAL, bus.oPIX);
    end
    clear_mon();
    repeat (2) @(posedge iCLK);
    #1; iRST = 1'b0;
    exp_rows(0);
    drive_frame(1'b0, -1, 2'd0);
    checks++; if (out_q.size() != N) begin errors++; $display("FAIL rst_count: got %0d expected %0d", out_q.size(), N); end
    for (int i = 0; i < out_q.size() && i < N; i++) begin
      checks++; if (out_q[i] !== expv[i]) begin errors++; $display("FAIL rst_pix[%0d]: got %0d expected %0d", i, out_q[i], expv[i]); end
    end
  endtask

`ifdef CONV_EDGE_STATS_EN
  task automatic test_edge_stats();
    iRST = 1'b1;
    repeat (2) @(posedge iCLK);
    #1; iRST = 1'b0;
    fill_vert(); conv_en = 1'b1; mode = 2'd0; clear_mon();
    drive_frame(1'b0, -1, 2'd0);
    checks++; if (edge_pulses !== 1) begin errors++; $display("FAIL stats_pulses: got %0d expected 1", edge_pulses); end
    checks++; if (edge_val !== 8) begin errors++; $display("FAIL stats_cnt: got %0d expected 8", edge_val); end
    checks++; if (in_cyc.size() == N && edge_cyc !== in_cyc[N-1] + 3) begin
      errors++; $display("FAIL stats_cyc: got %0d expected %0d", edge_cyc, in_cyc[N-1] + 3);
    end
  endtask
`endif

  initial begin
    iRST = 1'b1; bus.iPIX = '0; bus.iDVAL = 1'b0; bus.iSOF = 1'b0;
    conv_en = 1'b1; mode = 2'd0; thresh = '0;
    hold_err = 0; last_out = '0; edge_pulses = 0; edge_val = 0; edge_cyc = 0;
    test_reset();
    test_vertical_edge();
    test_threshold();
    test_gauss();
    test_bubbles();
    test_bypass();
    test_config_latch();
    test_mid_reset();
`ifdef CONV_EDGE_STATS_EN
    test_edge_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
